// File: rtl/tinyproc_pkg.sv
// tinyproc_pkg
// Shared definitions for the tinyproc core and its program loader:
// instruction/program-memory geometry, the loader frame header byte,
// the loader state type and the opcode field values the core decodes.
package tinyproc_pkg;

   localparam int INSTR_WIDTH   = 11;
   localparam int PM_ADDR_WIDTH = 8;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Number of instruction bits carried by the HI byte of a word pair.
   localparam int HI_BITS = INSTR_WIDTH - 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_HI,
      S_LO,
      S_CHECK,
      S_DONE,
      S_ERROR
   } loader_state_t;

   // Opcode field (word[10:8]) values used by the core's decoder.
   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_LDI = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_LD  = 3'd4;
   localparam logic [2:0] OP_ST  = 3'd5;
   localparam logic [2:0] OP_JMP = 3'd6;
   localparam logic [2:0] OP_JZ  = 3'd7;

endpackage

// File: rtl/tinyproc_loader_if.sv
// tinyproc_loader_if
// Groups the loader's byte-stream handshake, program-memory write port and
// status outputs.
//   in_valid/in_data  : byte source -> loader
//   in_ready          : loader -> byte source
//   pm_we/addr/wdata  : loader -> program memory (one-cycle write pulse)
//   cpu_run           : 1 = core may execute
//   load_error        : last frame rejected
// Modport slave is the loader; modport master is the environment around it.
interface tinyproc_loader_if;
   import tinyproc_pkg::*;

   logic                     in_valid;
   logic [7:0]               in_data;
   logic                     in_ready;
   logic                     pm_we;
   logic [PM_ADDR_WIDTH-1:0] pm_addr;
   logic [INSTR_WIDTH-1:0]   pm_wdata;
   logic                     cpu_run;
   logic                     load_error;

   modport master (
      output in_valid, in_data,
      input  in_ready, pm_we, pm_addr, pm_wdata, cpu_run, load_error
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, pm_we, pm_addr, pm_wdata, cpu_run, load_error
   );

endinterface

// File: rtl/tinyproc_loader.sv
// tinyproc_loader
// Byte-stream program loader. Parses frames of the form
//   SYNC, COUNT, COUNT x (HI, LO), CHK
// writes each assembled 11-bit word to program memory, verifies the frame
// checksum and releases the core (cpu_run) only after a good frame.
// Ports:
//   clk   : clock, all state on posedge
//   reset : asynchronous active-high reset
//   bus   : tinyproc_loader_if.slave (byte stream in, program-memory write
//           port, cpu_run and load_error status out)
module tinyproc_loader
   import tinyproc_pkg::*;
(
   input logic              clk,
   input logic              reset,
   tinyproc_loader_if.slave bus
);

   localparam logic [PM_ADDR_WIDTH:0] ADDR_ONE = 1;

   loader_state_t            state;
   logic                     ready_q;
   logic                     we_q;
   logic [PM_ADDR_WIDTH-1:0] waddr_q;
   logic [INSTR_WIDTH-1:0]   wdata_q;
   logic                     run_q;
   logic                     err_q;

   // One bit wider than the memory address so a COUNT of 0 (256 words)
   // is representable and the terminal compare works.
   logic [PM_ADDR_WIDTH:0]   word_count;
   logic [PM_ADDR_WIDTH:0]   addr;
   logic [7:0]               sum;
   logic [HI_BITS-1:0]       hi_q;

   logic                     accept;
   logic [PM_ADDR_WIDTH:0]   addr_inc;
   logic [7:0]               byte_sum;

   assign accept   = bus.in_valid && ready_q;
   assign addr_inc = addr + ADDR_ONE;
   assign byte_sum = sum + bus.in_data;

   assign bus.in_ready   = ready_q;
   assign bus.pm_we      = we_q;
   assign bus.pm_addr    = waddr_q;
   assign bus.pm_wdata   = wdata_q;
   assign bus.cpu_run    = run_q;
   assign bus.load_error = err_q;

   // Frame parser. Every output is registered here; the write strobe is
   // cleared each cycle so it only ever pulses for the cycle after a LO byte.
   // in_ready only drops on entry to DONE, which is left solely by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         ready_q    <= 1'b1;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         run_q      <= 1'b0;
         err_q      <= 1'b0;
         word_count <= '0;
         addr       <= '0;
         sum        <= '0;
         hi_q       <= '0;
      end else begin
         we_q <= 1'b0;
         if (accept) begin
            case (state)
               S_IDLE, S_ERROR: begin
                  if (bus.in_data == SYNC_BYTE) begin
                     err_q <= 1'b0;
                     state <= S_COUNT;
                  end
               end
               S_COUNT: begin
                  // A zero count byte means a full 256-word image.
                  word_count <= {(bus.in_data == 8'd0), bus.in_data};
                  addr       <= '0;
                  sum        <= '0;
                  state      <= S_HI;
               end
               S_HI: begin
                  if (bus.in_data[7:HI_BITS] != '0) begin
                     err_q <= 1'b1;
                     run_q <= 1'b0;
                     state <= S_ERROR;
                  end else begin
                     hi_q  <= bus.in_data[HI_BITS-1:0];
                     sum   <= byte_sum;
                     state <= S_LO;
                  end
               end
               S_LO: begin
                  sum     <= byte_sum;
                  we_q    <= 1'b1;
                  waddr_q <= addr[PM_ADDR_WIDTH-1:0];
                  wdata_q <= {hi_q, bus.in_data};
                  addr    <= addr_inc;
                  state   <= (addr_inc == word_count) ? S_CHECK : S_HI;
               end
               S_CHECK: begin
                  if (byte_sum == 8'd0) begin
                     run_q   <= 1'b1;
                     ready_q <= 1'b0;
                     state   <= S_DONE;
                  end else begin
                     err_q <= 1'b1;
                     run_q <= 1'b0;
                     state <= S_ERROR;
                  end
               end
               default: begin
                  state <= state;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tinyproc_loader.sv
// tb_tinyproc_loader
// Self-checking bench for tinyproc_loader. A frame-level reference model
// scans the byte stream and predicts the program-memory writes and the final
// cpu_run / load_error status; a monitor records every write pulse.
`timescale 1ns/1ps
module tb_tinyproc_loader;
   import tinyproc_pkg::*;

   typedef logic [7:0]  bq_t[$];
   typedef logic [18:0] wq_t[$];

   logic clk = 1'b0;
   logic reset;
   int   n_cmp  = 0;
   int   n_fail = 0;
   wq_t  seen;

   tinyproc_loader_if bus();

   tinyproc_loader dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Record every write pulse as {addr, data}.
   always @(negedge clk) begin
      if (bus.pm_we === 1'b1) seen.push_back({bus.pm_addr, bus.pm_wdata});
   end

   task automatic do_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      seen.delete();
   endtask

   // Present one byte and hold it until the posedge that consumes it;
   // returns at the negedge after consumption.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int waited;
      if (gaps) begin
         bus.in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data = b;
      waited = 0;
      while (bus.in_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (bus.in_ready !== 1'b1) begin
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL in_ready_timeout: in_ready=%b required 1 (byte %02h)", bus.in_ready, b);
         bus.in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_stream(input bq_t s, input bit gaps);
      foreach (s[i]) send_byte(s[i], gaps);
      repeat (2) @(negedge clk);
   endtask

   // Build a well-formed frame (valid checksum) around a list of words.
   function automatic bq_t make_frame(input logic [10:0] words[$]);
      bq_t f;
      int  total;
      f = {};
      total = 0;
      f.push_back(SYNC_BYTE);
      f.push_back(8'(words.size() % 256));
      foreach (words[k]) begin
         f.push_back({5'b0, words[k][10:8]});
         f.push_back(words[k][7:0]);
         total += int'(words[k][10:8]) + int'(words[k][7:0]);
      end
      f.push_back(8'((256 - (total % 256)) % 256));
      return f;
   endfunction

   // Reference model: scan for SYNC, read COUNT and the word pairs, then the
   // checksum; an illegal HI or a bad checksum flags an error and scanning
   // resumes looking for the next SYNC. Stops at the first good frame.
   task automatic model(input bq_t s, output wq_t w, output bit run, output bit err);
      int i, n, total;
      bit bad, short_frame;
      logic [7:0] hi, lo;
      w = {};
      run = 1'b0;
      err = 1'b0;
      i = 0;
      while (i < s.size() && !run) begin
         if (s[i] != SYNC_BYTE) begin
            i++;
            continue;
         end
         err = 1'b0;
         i++;
         if (i >= s.size()) break;
         n = (s[i] == 8'h00) ? 256 : int'(s[i]);
         i++;
         total = 0;
         bad = 1'b0;
         short_frame = 1'b0;
         for (int k = 0; k < n; k++) begin
            if (i >= s.size()) begin short_frame = 1'b1; break; end
            hi = s[i];
            i++;
            if (hi > 8'h07) begin bad = 1'b1; break; end
            if (i >= s.size()) begin short_frame = 1'b1; break; end
            lo = s[i];
            i++;
            w.push_back({8'(k), hi[2:0], lo});
            total += int'(hi) + int'(lo);
         end
         if (short_frame) break;
         if (bad) begin
            err = 1'b1;
            continue;
         end
         if (i >= s.size()) break;
         if ((total + int'(s[i])) % 256 == 0) run = 1'b1;
         else err = 1'b1;
         i++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      n_cmp++;
      if (bus.pm_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pm_we: got %b want 0", bus.pm_we); end
      n_cmp++;
      if (bus.pm_addr !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_pm_addr: got %h want 00", bus.pm_addr); end
      n_cmp++;
      if (bus.pm_wdata !== 11'h000) begin n_fail++; $display("[TB] FAIL reset_pm_wdata: got %h want 000", bus.pm_wdata); end
      n_cmp++;
      if (bus.cpu_run !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cpu_run: got %b want 0", bus.cpu_run); end
      n_cmp++;
      if (bus.load_error !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_load_error: got %b want 0", bus.load_error); end
   endtask

   task automatic test_good_frame();
      bq_t s;
      wq_t ew;
      bit  er, ee;
      s = {8'hA5, 8'h02, 8'h04, 8'h10, 8'h02, 8'h05, 8'hE5};
      do_reset();
      foreach (s[i]) begin
         send_byte(s[i], 1'b0);
         if (i == 3) begin
            n_cmp++;
            if (bus.pm_we !== 1'b1 || bus.pm_addr !== 8'd0 || bus.pm_wdata !== 11'h410) begin
               n_fail++;
               $display("[TB] FAIL good_write0: got we=%b addr=%h data=%h want we=1 addr=00 data=410", bus.pm_we, bus.pm_addr, bus.pm_wdata);
            end
         end
         if (i == 5) begin
            n_cmp++;
            if (bus.pm_we !== 1'b1 || bus.pm_addr !== 8'd1 || bus.pm_wdata !== 11'h205) begin
               n_fail++;
               $display("[TB] FAIL good_write1: got we=%b addr=%h data=%h want we=1 addr=01 data=205", bus.pm_we, bus.pm_addr, bus.pm_wdata);
            end
         end
         if (i == 6) begin
            n_cmp++;
            if (bus.cpu_run !== 1'b1 || bus.in_ready !== 1'b0 || bus.pm_we !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL good_done: got run=%b ready=%b we=%b want run=1 ready=0 we=0", bus.cpu_run, bus.in_ready, bus.pm_we);
            end
         end
      end
      repeat (2) @(negedge clk);
      model(s, ew, er, ee);
      n_cmp++;
      if (seen.size() != ew.size()) begin n_fail++; $display("[TB] FAIL good_write_count: got %0d want %0d", seen.size(), ew.size()); end
      for (int k = 0; k < ew.size() && k < seen.size(); k++) begin
         n_cmp++;
         if (seen[k] !== ew[k]) begin n_fail++; $display("[TB] FAIL good_write[%0d]: got %h want %h", k, seen[k], ew[k]); end
      end
   endtask

   task automatic test_bad_checksum();
      bq_t s;
      wq_t ew;
      bit  er, ee;
      do_reset();
      s = {8'hA5, 8'h01, 8'h03, 8'h07, 8'h00};
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) s = {8'hA5, 8'h01, 8'h03, 8'h07, 8'hF6};
         seen.delete();
         send_stream(s, 1'b0);
         model(s, ew, er, ee);
         n_cmp++;
         if (seen.size() != ew.size()) begin n_fail++; $display("[TB] FAIL chk%0d_write_count: got %0d want %0d", pass, seen.size(), ew.size()); end
         for (int k = 0; k < ew.size() && k < seen.size(); k++) begin
            n_cmp++;
            if (seen[k] !== ew[k]) begin n_fail++; $display("[TB] FAIL chk%0d_write[%0d]: got %h want %h", pass, k, seen[k], ew[k]); end
         end
         n_cmp++;
         if (bus.cpu_run !== er || bus.load_error !== ee) begin
            n_fail++;
            $display("[TB] FAIL chk%0d_status: got run=%b err=%b want run=%b err=%b", pass, bus.cpu_run, bus.load_error, er, ee);
         end
      end
   endtask

   task automatic test_bad_hi();
      do_reset();
      send_byte(8'hA5, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h08, 1'b0);
      n_cmp++;
      if (bus.load_error !== 1'b1 || bus.cpu_run !== 1'b0 || bus.pm_we !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL bad_hi_status: got err=%b run=%b we=%b want err=1 run=0 we=0", bus.load_error, bus.cpu_run, bus.pm_we);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (seen.size() != 0) begin n_fail++; $display("[TB] FAIL bad_hi_writes: got %0d want 0", seen.size()); end
   endtask

   task automatic test_garbage();
      bq_t s;
      wq_t ew;
      bit  er, ee;
      s = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h01, 8'hFF};
      do_reset();
      send_stream(s, 1'b1);
      model(s, ew, er, ee);
      n_cmp++;
      if (seen.size() != ew.size()) begin n_fail++; $display("[TB] FAIL garbage_write_count: got %0d want %0d", seen.size(), ew.size()); end
      for (int k = 0; k < ew.size() && k < seen.size(); k++) begin
         n_cmp++;
         if (seen[k] !== ew[k]) begin n_fail++; $display("[TB] FAIL garbage_write[%0d]: got %h want %h", k, seen[k], ew[k]); end
      end
      n_cmp++;
      if (bus.cpu_run !== er || bus.load_error !== ee) begin
         n_fail++;
         $display("[TB] FAIL garbage_status: got run=%b err=%b want run=%b err=%b", bus.cpu_run, bus.load_error, er, ee);
      end
   endtask

   task automatic test_random_frames();
      bq_t s, f;
      wq_t ew;
      bit  er, ee;
      logic [10:0] words[$];
      logic [7:0]  g;
      int mode, n, j;
      for (int it = 0; it < 8; it++) begin
         do_reset();
         s = {};
         repeat ($urandom_range(0, 3)) begin
            g = 8'($urandom_range(0, 255));
            if (g == SYNC_BYTE) g = 8'h00;
            s.push_back(g);
         end
         words = {};
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) words.push_back(11'($urandom_range(0, 2047)));
         f = make_frame(words);
         mode = $urandom_range(0, 2);
         if (mode == 1) begin
            f[f.size()-1] = f[f.size()-1] ^ 8'($urandom_range(1, 255));
         end else if (mode == 2) begin
            j = $urandom_range(0, n - 1);
            f[2 + 2*j] = {5'($urandom_range(1, 31)), f[2 + 2*j][2:0]};
            while (f.size() > 3 + 2*j) f.pop_back();
         end
         foreach (f[k]) s.push_back(f[k]);
         send_stream(s, 1'b1);
         model(s, ew, er, ee);
         n_cmp++;
         if (seen.size() != ew.size()) begin n_fail++; $display("[TB] FAIL rand%0d_write_count: got %0d want %0d", it, seen.size(), ew.size()); end
         for (int k = 0; k < ew.size() && k < seen.size(); k++) begin
            n_cmp++;
            if (seen[k] !== ew[k]) begin n_fail++; $display("[TB] FAIL rand%0d_write[%0d]: got %h want %h", it, k, seen[k], ew[k]); end
         end
         n_cmp++;
         if (bus.cpu_run !== er || bus.load_error !== ee) begin
            n_fail++;
            $display("[TB] FAIL rand%0d_status: got run=%b err=%b want run=%b err=%b", it, bus.cpu_run, bus.load_error, er, ee);
         end
      end
   endtask

   task automatic test_full_frame();
      bq_t s;
      wq_t ew;
      bit  er, ee;
      logic [10:0] words[$];
      words = {};
      for (int k = 0; k < 256; k++) words.push_back(11'($urandom_range(0, 2047)));
      s = make_frame(words);
      do_reset();
      send_stream(s, 1'b1);
      model(s, ew, er, ee);
      n_cmp++;
      if (seen.size() != ew.size()) begin n_fail++; $display("[TB] FAIL full_write_count: got %0d want %0d", seen.size(), ew.size()); end
      for (int k = 0; k < ew.size() && k < seen.size(); k++) begin
         n_cmp++;
         if (seen[k] !== ew[k]) begin n_fail++; $display("[TB] FAIL full_write[%0d]: got %h want %h", k, seen[k], ew[k]); end
      end
      n_cmp++;
      if (bus.cpu_run !== 1'b1 || bus.load_error !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL full_status: got run=%b err=%b want run=1 err=0", bus.cpu_run, bus.load_error);
      end
   endtask

   task automatic test_reset_mid_frame();
      bq_t f, part, s;
      wq_t ew;
      bit  er, ee;
      logic [10:0] words[$];
      words = {11'h1F0, 11'h002, 11'h3C4, 11'h123, 11'h055};
      f = make_frame(words);
      part = {};
      for (int k = 0; k < 9; k++) part.push_back(f[k]);
      do_reset();
      foreach (part[k]) send_byte(part[k], 1'b0);
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.pm_we !== 1'b0 || bus.pm_addr !== 8'h00 || bus.pm_wdata !== 11'h000 ||
          bus.cpu_run !== 1'b0 || bus.load_error !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midreset_outputs: got ready=%b we=%b addr=%h data=%h run=%b err=%b want 1 0 00 000 0 0",
                  bus.in_ready, bus.pm_we, bus.pm_addr, bus.pm_wdata, bus.cpu_run, bus.load_error);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      model(part, ew, er, ee);
      n_cmp++;
      if (seen.size() != ew.size()) begin n_fail++; $display("[TB] FAIL midreset_write_count: got %0d want %0d", seen.size(), ew.size()); end
      for (int k = 0; k < ew.size() && k < seen.size(); k++) begin
         n_cmp++;
         if (seen[k] !== ew[k]) begin n_fail++; $display("[TB] FAIL midreset_write[%0d]: got %h want %h", k, seen[k], ew[k]); end
      end
      seen.delete();
      words = {};
      for (int k = 0; k < 4; k++) words.push_back(11'($urandom_range(0, 2047)));
      s = {8'h23};
      f = make_frame(words);
      foreach (f[k]) s.push_back(f[k]);
      send_stream(s, 1'b0);
      model(s, ew, er, ee);
      n_cmp++;
      if (seen.size() != ew.size()) begin n_fail++; $display("[TB] FAIL reload_write_count: got %0d want %0d", seen.size(), ew.size()); end
      for (int k = 0; k < ew.size() && k < seen.size(); k++) begin
         n_cmp++;
         if (seen[k] !== ew[k]) begin n_fail++; $display("[TB] FAIL reload_write[%0d]: got %h want %h", k, seen[k], ew[k]); end
      end
      n_cmp++;
      if (bus.cpu_run !== er || bus.load_error !== ee) begin
         n_fail++;
         $display("[TB] FAIL reload_status: got run=%b err=%b want run=%b err=%b", bus.cpu_run, bus.load_error, er, ee);
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_bad_hi();
      test_garbage();
      test_random_frames();
      test_full_frame();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
